// File: rtl/mrnaiso_sequencer_if.sv
// rtl/mrnaiso_sequencer_if.sv - run-control and actuation bundle for the mRNA isolation sequencer
interface mrnaiso_sequencer_if;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [3:0]  phase;
    logic [12:0] ctrl;
    logic [12:0] flush;

    modport master (output start, abort, input busy, done, phase, ctrl, flush);
    modport slave  (input start, abort, output busy, done, phase, ctrl, flush);
endinterface

// File: rtl/mrnaiso_sequencer.sv
// rtl/mrnaiso_sequencer.sv - timed valve/pump sequencer for one mRNA isolation run
// Optional FLUSH phase enabled by defining MRNAISO_FLUSH_EN.
module mrnaiso_sequencer #(
    parameter int unsigned T_LOAD   = 16,
    parameter int unsigned T_LYSIS  = 32,
    parameter int unsigned T_MIX    = 64,
    parameter int unsigned T_SEP    = 32,
    parameter int unsigned PUMP_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    mrnaiso_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD_CELLS = 4'd1,
        S_LOAD_BEADS = 4'd2,
        S_LYSIS      = 4'd3,
        S_MIX        = 4'd4,
        S_SEP        = 4'd5,
        S_WASTE      = 4'd6,
        S_COLLECT    = 4'd7,
        S_FLUSH      = 4'd8,
        S_DONE       = 4'd9
    } state_t;

    localparam int B_CELLS_IN  = 0;
    localparam int B_BEADS     = 1;
    localparam int B_LYSIS_IN  = 2;
    localparam int B_LYSIS_OUT = 3;
    localparam int B_PUMP1     = 4;
    localparam int B_PUMP2     = 5;
    localparam int B_PUMP3     = 6;
    localparam int B_SEP       = 7;
    localparam int B_SIEVE     = 8;
    localparam int B_WASTE     = 9;
    localparam int B_PUSH      = 10;
    localparam int B_COLLECT   = 11;
    localparam int B_CELLS_OUT = 12;

    localparam logic [7:0] DIV_LAST = 8'(PUMP_DIV - 1);
    localparam logic [2:0] PAT_INIT = 3'b100;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  pat_q, pat_d;
    logic [7:0]  div_q, div_d;
    logic [12:0] ctrl_c;
    logic [12:0] flush_c;

    function automatic logic [15:0] dur_m1(input state_t s);
        case (s)
            S_LOAD_CELLS, S_LOAD_BEADS, S_COLLECT, S_FLUSH: dur_m1 = 16'(T_LOAD - 1);
            S_LYSIS:                                        dur_m1 = 16'(T_LYSIS - 1);
            S_MIX:                                          dur_m1 = 16'(T_MIX - 1);
            S_SEP, S_WASTE:                                 dur_m1 = 16'(T_SEP - 1);
            default:                                        dur_m1 = 16'd0;
        endcase
    endfunction

    function automatic state_t next_run(input state_t s);
        case (s)
            S_LOAD_CELLS: next_run = S_LOAD_BEADS;
            S_LOAD_BEADS: next_run = S_LYSIS;
            S_LYSIS:      next_run = S_MIX;
            S_MIX:        next_run = S_SEP;
            S_SEP:        next_run = S_WASTE;
            S_WASTE:      next_run = S_COLLECT;
`ifdef MRNAISO_FLUSH_EN
            S_COLLECT:    next_run = S_FLUSH;
`else
            S_COLLECT:    next_run = S_DONE;
`endif
            default:      next_run = S_IDLE;
        endcase
    endfunction

    // Pattern held as {pump1, pump2, pump3}: 100,110,010,011,001,101.
    function automatic logic [2:0] pump_next(input logic [2:0] p);
        case (p)
            3'b100:  pump_next = 3'b110;
            3'b110:  pump_next = 3'b010;
            3'b010:  pump_next = 3'b011;
            3'b011:  pump_next = 3'b001;
            3'b001:  pump_next = 3'b101;
            default: pump_next = 3'b100;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pat_q   <= PAT_INIT;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start && !bus.abort) begin
                    state_d = S_LOAD_CELLS;
                    cnt_d   = dur_m1(S_LOAD_CELLS);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            S_FLUSH: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                if (bus.abort) begin
`ifdef MRNAISO_FLUSH_EN
                    state_d = S_FLUSH;
                    cnt_d   = dur_m1(S_FLUSH);
`else
                    state_d = S_DONE;
                    cnt_d   = '0;
`endif
                end else if (cnt_q == 16'd0) begin
                    state_d = next_run(state_q);
                    cnt_d   = dur_m1(next_run(state_q));
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

    // Pump phase restarts on LYSIS entry and free-runs through MIX.
    always_comb begin
        pat_d = pat_q;
        div_d = div_q;
        if (state_d == S_LYSIS && state_q != S_LYSIS) begin
            pat_d = PAT_INIT;
            div_d = '0;
        end else if (state_q == S_LYSIS || state_q == S_MIX) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                pat_d = pump_next(pat_q);
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_comb begin
        ctrl_c  = '0;
        flush_c = '0;
        case (state_q)
            S_LOAD_CELLS: begin
                ctrl_c[B_CELLS_IN] = 1'b1;
                ctrl_c[B_PUSH]     = 1'b1;
            end
            S_LOAD_BEADS: begin
                ctrl_c[B_BEADS] = 1'b1;
                ctrl_c[B_PUSH]  = 1'b1;
            end
            S_LYSIS: begin
                ctrl_c[B_LYSIS_IN]  = 1'b1;
                ctrl_c[B_LYSIS_OUT] = 1'b1;
                ctrl_c[B_PUMP1]     = pat_q[2];
                ctrl_c[B_PUMP2]     = pat_q[1];
                ctrl_c[B_PUMP3]     = pat_q[0];
            end
            S_MIX: begin
                ctrl_c[B_PUMP1] = pat_q[2];
                ctrl_c[B_PUMP2] = pat_q[1];
                ctrl_c[B_PUMP3] = pat_q[0];
            end
            S_SEP: begin
                ctrl_c[B_SEP]   = 1'b1;
                ctrl_c[B_SIEVE] = 1'b1;
            end
            S_WASTE: begin
                ctrl_c[B_SIEVE] = 1'b1;
                ctrl_c[B_WASTE] = 1'b1;
                ctrl_c[B_PUSH]  = 1'b1;
            end
            S_COLLECT: begin
                ctrl_c[B_SEP]       = 1'b1;
                ctrl_c[B_COLLECT]   = 1'b1;
                ctrl_c[B_PUSH]      = 1'b1;
                ctrl_c[B_CELLS_OUT] = 1'b1;
            end
`ifdef MRNAISO_FLUSH_EN
            S_FLUSH: flush_c = '1;
`endif
            default: ;
        endcase
    end

    // Outputs are masked during reset so actuators drop at once.
    assign bus.busy  = !rst && (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done  = !rst && (state_q == S_DONE);
    assign bus.phase = rst ? 4'd0 : state_q;
    assign bus.ctrl  = rst ? 13'd0 : ctrl_c;
    assign bus.flush = rst ? 13'd0 : flush_c;

endmodule

// File: tb/tb_mrnaiso_sequencer.sv
// tb/tb_mrnaiso_sequencer.sv - directed self-checking bench for mrnaiso_sequencer
module tb_mrnaiso_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mrnaiso_sequencer_if bus_if ();

    mrnaiso_sequencer #(
        .T_LOAD(16), .T_LYSIS(32), .T_MIX(64), .T_SEP(32), .PUMP_DIV(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

`ifdef MRNAISO_FLUSH_EN
    localparam int EXP_RUN = 224;
`else
    localparam int EXP_RUN = 208;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_phase(input int k);
        if (k < 16)       return 4'd1;
        else if (k < 32)  return 4'd2;
        else if (k < 64)  return 4'd3;
        else if (k < 128) return 4'd4;
        else if (k < 160) return 4'd5;
        else if (k < 192) return 4'd6;
        else if (k < 208) return 4'd7;
        else              return 4'd8;
    endfunction

    // ctrl[6:4] = {pump3, pump2, pump1} for patterns 100,110,010,011,001,101.
    function automatic logic [12:0] pump_bits(input int k);
        case (((k - 32) / 4) % 6)
            0:       return 13'h010;
            1:       return 13'h030;
            2:       return 13'h020;
            3:       return 13'h060;
            4:       return 13'h040;
            default: return 13'h050;
        endcase
    endfunction

    function automatic logic [12:0] exp_ctrl(input int k);
        case (exp_phase(k))
            4'd1:    return 13'h0401;
            4'd2:    return 13'h0402;
            4'd3:    return 13'h000C | pump_bits(k);
            4'd4:    return pump_bits(k);
            4'd5:    return 13'h0180;
            4'd6:    return 13'h0700;
            4'd7:    return 13'h1C80;
            default: return 13'h0000;
        endcase
    endfunction

    initial begin
        int k;
        int saw_done;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_phase", 32'(bus_if.phase), 32'd0);
        chk("rst_busy",  32'(bus_if.busy),  32'd0);
        chk("rst_done",  32'(bus_if.done),  32'd0);
        chk("rst_ctrl",  32'(bus_if.ctrl),  32'd0);
        chk("rst_flush", 32'(bus_if.flush), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_phase", 32'(bus_if.phase), 32'd0);

        // Full run, with a stray start mid-run that must be ignored
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        k = 0;
        while (bus_if.busy && k < 400) begin
            chk($sformatf("run_phase k=%0d", k), 32'(bus_if.phase), 32'(exp_phase(k)));
            chk($sformatf("run_ctrl k=%0d", k),  32'(bus_if.ctrl),  32'(exp_ctrl(k)));
            chk($sformatf("run_flush k=%0d", k), 32'(bus_if.flush),
                (exp_phase(k) == 4'd8) ? 32'h1FFF : 32'd0);
            chk($sformatf("run_done k=%0d", k),  32'(bus_if.done),  32'd0);
            bus_if.start = (k == 5);
            k++;
            @(negedge clk);
        end
        bus_if.start = 1'b0;
        chk("run_busy_len", 32'(k), 32'(EXP_RUN));
        chk("run_done_pulse", 32'(bus_if.done), 32'd1);
        chk("run_done_phase", 32'(bus_if.phase), 32'd9);
        @(negedge clk);
        chk("run_done_drop", 32'(bus_if.done), 32'd0);
        chk("run_back_idle", 32'(bus_if.phase), 32'd0);

        // Abort at cycle 50 (in LYSIS)
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int i = 0; i < 50; i++) @(negedge clk);
        chk("abt_pre_phase", 32'(bus_if.phase), 32'd3);
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
`ifdef MRNAISO_FLUSH_EN
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("abt_flush_phase i=%0d", i), 32'(bus_if.phase), 32'd8);
            chk($sformatf("abt_flush_bits i=%0d", i),  32'(bus_if.flush), 32'h1FFF);
            chk($sformatf("abt_flush_ctrl i=%0d", i),  32'(bus_if.ctrl),  32'd0);
            chk($sformatf("abt_flush_busy i=%0d", i),  32'(bus_if.busy),  32'd1);
            @(negedge clk);
        end
`endif
        chk("abt_done_pulse", 32'(bus_if.done),  32'd1);
        chk("abt_done_phase", 32'(bus_if.phase), 32'd9);
        chk("abt_done_ctrl",  32'(bus_if.ctrl),  32'd0);
        chk("abt_done_flush", 32'(bus_if.flush), 32'd0);
        @(negedge clk);
        chk("abt_idle_phase", 32'(bus_if.phase), 32'd0);
        chk("abt_idle_done",  32'(bus_if.done),  32'd0);

        // Start and abort together in IDLE: abort wins
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        chk("sa_phase", 32'(bus_if.phase), 32'd0);
        chk("sa_busy",  32'(bus_if.busy),  32'd0);
        @(negedge clk);
        chk("sa_phase2", 32'(bus_if.phase), 32'd0);

        // Reset during MIX: outputs clear immediately, no flush, no done
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int i = 0; i < 70; i++) @(negedge clk);
        chk("mix_phase", 32'(bus_if.phase), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_ctrl",  32'(bus_if.ctrl),  32'd0);
        chk("mrst_flush", 32'(bus_if.flush), 32'd0);
        chk("mrst_phase", 32'(bus_if.phase), 32'd0);
        chk("mrst_done",  32'(bus_if.done),  32'd0);
        rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.done || bus_if.busy || bus_if.flush != 13'd0) saw_done++;
        end
        chk("mrst_quiet", 32'(saw_done), 32'd0);
        chk("mrst_idle",  32'(bus_if.phase), 32'd0);

        // Abort in IDLE is ignored
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_done", 32'(bus_if.done),  32'd0);
        chk("idle_abort_phase", 32'(bus_if.phase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
